program_loader: RTL and testbench



---
 rtl/program_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_program_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Boot-time loader between a byte stream and the instruction memory. It takes a
// little-endian image (2-byte word count, then 3 bytes per word), writes each
// assembled word to consecutive instruction-memory addresses starting at 0, and
// holds the core in reset until the whole image has been written.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, a trailing checksum byte (XOR of every word byte) is expected.
//   A mismatch lands in a terminal error state that keeps the core in reset.
//
// Parameters:
//   ADDR_W   instruction address width, also the word-count width (9..16)
//   INSTR_W  instruction width (17..24, so one word fits in 3 bytes)
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   in_data   stream byte
//   in_valid  in_data is valid
//   in_ready  loader can accept a byte (registered, decoded from state)
//   im_we     instruction-memory write strobe, one cycle per word
//   im_addr   instruction-memory write address
//   im_wdata  instruction-memory write data
//   core_rst  reset to the core, high until the image is accepted
//   done      image loaded and accepted (sticky until rst)
//   error     image rejected (checksum build only; tied 0 otherwise)
//
// Handshake: a byte transfers on a rising edge where in_valid and in_ready
// are both high. in_ready does not depend on in_valid; the producer may hold
// in_valid low for any number of cycles without changing the loader state.
// -----------------------------------------------------------------------------
module program_loader #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 19
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               im_we,
    output logic [ADDR_W-1:0]  im_addr,
    output logic [INSTR_W-1:0] im_wdata,
    output logic               core_rst,
    output logic               done,
    output logic               error
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_HDR0 = 3'd0,
        S_HDR1 = 3'd1,
        S_B0   = 3'd2,
        S_B1   = 3'd3,
        S_B2   = 3'd4,
        S_DONE = 3'd5,
        S_CHK  = 3'd6,
        S_ERR  = 3'd7
    } state_t;
    // State entered after the last word (or an empty header).
    localparam state_t S_LAST = S_CHK;
`else
    typedef enum logic [2:0] {
        S_HDR0 = 3'd0,
        S_HDR1 = 3'd1,
        S_B0   = 3'd2,
        S_B1   = 3'd3,
        S_B2   = 3'd4,
        S_DONE = 3'd5
    } state_t;
    localparam state_t S_LAST = S_DONE;
`endif

    // State register is kept visible by name for checkers bound to this block.
    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    n_q, n_d;          // word count from the header
    logic [ADDR_W-1:0]    word_idx_q, word_idx_d;
    logic [7:0]           b0_q, b0_d;        // staging: H0, then each B0
    logic [7:0]           b1_q, b1_d;        // staging: B1
    logic                 in_ready_q, in_ready_d;
    logic                 im_we_q, im_we_d;
    logic [ADDR_W-1:0]    im_addr_q, im_addr_d;
    logic [INSTR_W-1:0]   im_wdata_q, im_wdata_d;
    logic                 core_rst_q, core_rst_d;
    logic                 done_q, done_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]           csum_q, csum_d;
    logic                 error_q, error_d;
`endif

    logic                 accept;
    logic [ADDR_W-1:0]    n_hdr;
    logic [INSTR_W-1:0]   word_w;

    assign accept = in_valid & in_ready_q;
    // Truncating casts drop the unused upper bits of H1 and B2.
    assign n_hdr  = ADDR_W'({in_data, b0_q});
    assign word_w = INSTR_W'({in_data, b1_q, b0_q});

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_idx_d = word_idx_q;
        b0_d       = b0_q;
        b1_d       = b1_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        if (accept) begin
            case (state_q)
                S_HDR0: begin
                    b0_d    = in_data;
                    state_d = S_HDR1;
                end
                S_HDR1: begin
                    n_d     = n_hdr;
                    state_d = (n_hdr == '0) ? S_LAST : S_B0;
                end
                S_B0: begin
                    b0_d    = in_data;
                    state_d = S_B1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ in_data;
`endif
                end
                S_B1: begin
                    b1_d    = in_data;
                    state_d = S_B2;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ in_data;
`endif
                end
                S_B2: begin
                    // Word moves to the write register, freeing the staging
                    // registers so the next B0 can land in the write cycle.
                    im_we_d    = 1'b1;
                    im_addr_d  = word_idx_q;
                    im_wdata_d = word_w;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ in_data;
`endif
                    // Index stops at N-1, so it cannot wrap even for the
                    // largest count.
                    if (word_idx_q == n_q - ADDR_W'(1)) begin
                        state_d = S_LAST;
                    end else begin
                        word_idx_d = word_idx_q + ADDR_W'(1);
                        state_d    = S_B0;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    state_d = (in_data == csum_q) ? S_DONE : S_ERR;
                end
`endif
                default: ;
            endcase
        end

        // Status outputs are registered copies decoded from the next state.
        in_ready_d = (state_d != S_DONE);
        core_rst_d = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
`ifdef LOADER_CHECKSUM_EN
        in_ready_d = (state_d != S_DONE) && (state_d != S_ERR);
        error_d    = (state_d == S_ERR);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HDR0;
            n_q        <= '0;
            word_idx_q <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
            in_ready_q <= 1'b1;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            word_idx_q <= word_idx_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
            in_ready_q <= in_ready_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
            error_q    <= error_d;
`endif
        end
    end

    assign in_ready = in_ready_q;
    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign core_rst = core_rst_q;
    assign done     = done_q;
`ifdef LOADER_CHECKSUM_EN
    assign error    = error_q;
`else
    assign error    = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Directed bench for program_loader. Expected memory writes are pushed into a
// queue by the stimulus process before the bytes are sent; a monitor on the
// falling edge pops and compares each im_we pulse. Status outputs are checked
// one delta after the edge on which the relevant byte is accepted.
// -----------------------------------------------------------------------------
module tb_program_loader;
    localparam int ADDR_W  = 12;
    localparam int INSTR_W = 19;
    localparam int EW      = ADDR_W + INSTR_W;

    logic               clk;
    logic               rst;
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic               im_we;
    logic [ADDR_W-1:0]  im_addr;
    logic [INSTR_W-1:0] im_wdata;
    logic               core_rst;
    logic               done;
    logic               error;

    int checks;
    int failures;
    logic [EW-1:0] exp_q[$];

    program_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .core_rst (core_rst),
        .done     (done),
        .error    (error)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_im_we"},    32'(im_we),    32'd0);
        check({tag, "_im_addr"},  32'(im_addr),  32'd0);
        check({tag, "_im_wdata"}, 32'(im_wdata), 32'd0);
        check({tag, "_core_rst"}, 32'(core_rst), 32'd1);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_error"},    32'(error),    32'd0);
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1; returns at posedge+1 right after the byte's edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int wait_cnt;
        wait_cnt = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && wait_cnt < 20) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: byte 0x%0h never accepted, in_ready=%0b required 1", b, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // Two-word image from the test plan; max_gap 0 means back-to-back bytes.
    task automatic send_two_word(input int max_gap, input logic [7:0] csum);
        logic [7:0] img[8];
        img = '{8'h02, 8'h00, 8'h45, 8'h23, 8'h01, 8'hFF, 8'hFF, 8'hFF};
        expect_write(12'd0, 19'h12345);
        expect_write(12'd1, 19'h7FFFF);
        for (int i = 0; i < 8; i++) begin
            send_byte(img[i], (max_gap == 0) ? 0 : (i == 7 ? 0 : int'($urandom_range(1, max_gap))));
        end
`ifdef LOADER_CHECKSUM_EN
        check("pre_csum_done", 32'(done), 32'd0);
        check("pre_csum_core_rst", 32'(core_rst), 32'd1);
        send_byte(csum, 0);
`else
        if (csum != 8'h00) $display("note: checksum byte unused in this build");
`endif
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (im_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: addr=0x%0h data=0x%0h, none required", im_addr, im_wdata);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("write_addr", 32'(im_addr), 32'(e[EW-1:INSTR_W]));
                check("write_data", 32'(im_wdata), 32'(e[INSTR_W-1:0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks   = 0;
        failures = 0;

        // Reset state
        do_reset();
        check_reset_values("reset");

        // Two-word image, in_valid held high
        send_two_word(0, 8'h98);
        check("img_done", 32'(done), 32'd1);
        check("img_core_rst", 32'(core_rst), 32'd0);
        check("img_in_ready", 32'(in_ready), 32'd0);
        check("img_error", 32'(error), 32'd0);
        @(posedge clk); #1;

        // Offer bytes after done: nothing accepted, nothing written
        in_data  = 8'hA5;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_done_in_ready", 32'(in_ready), 32'd0);
            check("post_done_done", 32'(done), 32'd1);
            check("post_done_core_rst", 32'(core_rst), 32'd0);
        end
        in_valid = 1'b0;
        check("img_queue_empty", 32'(exp_q.size()), 32'd0);

        // Same image with random stalls between bytes
        do_reset();
        send_two_word(3, 8'h98);
        check("stall_done", 32'(done), 32'd1);
        check("stall_core_rst", 32'(core_rst), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("stall_queue_empty", 32'(exp_q.size()), 32'd0);

        // Empty image; upper bits of H1 ignored
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'hF0, 0);
`ifdef LOADER_CHECKSUM_EN
        check("n0_done_before_csum", 32'(done), 32'd0);
        send_byte(8'h00, 0);
`endif
        check("n0_done", 32'(done), 32'd1);
        check("n0_core_rst", 32'(core_rst), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // Reset after the first word of a 3-word load
        do_reset();
        expect_write(12'd0, 19'h32211);
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h03, 0);
        // Write pulse is in flight now; the monitor consumes it at negedge.
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("midrst");
        rst = 1'b0;
        check("midrst_queue_empty", 32'(exp_q.size()), 32'd0);

        // 1-word reload overwrites address 0
        expect_write(12'd0, 19'h5BBAA);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'h05, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h14, 0);
`endif
        check("reload_done", 32'(done), 32'd1);
        check("reload_core_rst", 32'(core_rst), 32'd0);
        @(posedge clk);
        #1;
        check("reload_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: both writes still occur, then error
        do_reset();
        send_two_word(0, 8'h97);
        check("bad_error", 32'(error), 32'd1);
        check("bad_done", 32'(done), 32'd0);
        check("bad_core_rst", 32'(core_rst), 32'd1);
        check("bad_in_ready", 32'(in_ready), 32'd0);
        in_data  = 8'h98;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bad_hold_in_ready", 32'(in_ready), 32'd0);
            check("bad_hold_error", 32'(error), 32'd1);
        end
        in_valid = 1'b0;
        check("bad_queue_empty", 32'(exp_q.size()), 32'd0);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
